step_sequencer_arbiter: RTL and testbench
=========================================

Name: step_sequencer_arbiter

Overview:
- Shares one fixed-length step sequencer (STEPS clock steps, index 0..STEPS-1, then one completion cycle) among NREQ requesters using round-robin arbitration.
- Each requester raises req, receives a one-hot grant, then sees the step index with step_valid, then a one-cycle done pulse.
- Sits between the per-digit/per-channel load logic and the shared 150 kHz datapath; it is the sole generator of step indices in that domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STEPS, 4, steps per granted operation (2..16).
- IDX_W, 2, owner index width, = clog2(NREQ).
- STEP_W, 2, step index width, = clog2(STEPS).

Ports:
- clock150kHz  in  1  system clock; every flop is rising-edge.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  per-requester request level; hold high until done or abort.
- grant  out  NREQ  one-hot owner, all zero when idle.
- owner  out  IDX_W  binary index of current or last owner.
- step  out  STEP_W  current step index; 0 outside RUN.
- step_valid  out  1  high only in RUN.
- done  out  NREQ  one-hot one-cycle pulse to the owner on normal completion.
- aborted  out  1  one-cycle pulse when an owner drops req before completion.
- busy  out  1  high in GRANT, RUN, FINISH.

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clock150kHz.
- Outputs: all registered.
- Reset values: state=IDLE, grant=0, owner=0, step=0, step_valid=0, done=0, aborted=0, busy=0, rr pointer ptr=0.

State IDLE:
- If req!=0, the winner is the first set bit scanning ptr, ptr+1, ... mod NREQ. Latch owner and go to GRANT.
- Else stay in IDLE.

State GRANT (1 cycle):
- grant[owner]=1, busy=1, step=0, step_valid=0.
- If req[owner]=1, go to RUN with step=0.
- If req[owner]=0, abort.

State RUN (STEPS cycles):
- step_valid=1; step counts 0..STEPS-1, incrementing by 1 per cycle.
- When step==STEPS-1 and req[owner]=1, go to FINISH and return step to 0.
- If req[owner]=0 in any RUN cycle, abort (step_valid drops next cycle).

State FINISH (1 cycle):
- done[owner]=1, grant held, step_valid=0, ptr<=owner+1 mod NREQ.
- Go to IDLE.

Abort:
- Next cycle: state=IDLE, grant=0, step=0, aborted=1 for one cycle, no done pulse.
- ptr<=owner+1 mod NREQ, so the aborting requester loses its turn.

Timing and arbitration rules:
- Latency: req sampled high in IDLE at cycle t gives grant at t+1, step 0 at t+2, step STEPS-1 at t+STEPS+1, done at t+STEPS+2, IDLE at t+STEPS+3. Next grant no earlier than t+STEPS+4.
- Requests arriving while busy are ignored until IDLE; there is no queueing beyond the req level.
- A requester still holding req after done is re-arbitrated normally. Another pending requester wins first because ptr moved past the previous owner.
- Simultaneous requests are resolved strictly by ptr, with no fixed priority.
- With a single persistent requester and ptr past it, the scan wraps and it still wins.
- ptr wraps NREQ-1 -> 0; the step counter never exceeds STEPS-1.
- Reset mid-operation immediately forces reset values; no done or aborted is emitted.

Invariants:
- grant is one-hot or zero.
- done is never asserted alongside aborted.
- step_valid implies busy.

Decomposition:
- Shared package step_seq_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_GRANT=2'b01, ST_RUN=2'b10, ST_FINISH=2'b11;
  - default NREQ/STEPS values;
  - a clog2 function.
- Sub-module rr_pick: purely combinational; inputs req and ptr; outputs found and win_idx. It sits beside the FSM with its registers in the parent.

Test Plan:
- Reset: assert reset mid-RUN at step=2 -> all outputs 0 immediately and ptr=0; after release with req=4'b0000, everything stays idle.
- Single requester: req=4'b0010 at IDLE cycle t -> grant=0010 at t+1; step 0,1,2,3 with step_valid at t+2..t+5; done=0010 at t+6; grant=0 at t+7.
- Contention: req=4'b1111 held with ptr=0 -> owners 0,1,2,3,0 in order; each done is one cycle; spacing is 7 cycles per grant.
- Wrap: ptr=3 and req=4'b0101 -> owner 0 wins, then owner 2 on the next arbitration.
- Abort: requester 1 drops req at step=1 -> aborted=1 for one cycle next cycle, done stays 0, grant=0; with req=4'b0011 pending, requester 0 is not favoured over the rotation, so next owner=2 if present, else 0.
- Late request: req[2] rises during RUN of owner 0 -> not granted until IDLE; grant=0100 exactly one cycle after IDLE is re-entered.

Source files
------------

// File: rtl/step_seq_pkg.sv
// rtl/step_seq_pkg.sv - shared types and constants for the step sequencer arbiter
package step_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT  = 2'b01,
    ST_RUN    = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int STEPS_DEF = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/step_sequencer_arbiter_rr_pick.sv
// rtl/step_sequencer_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick
  import step_seq_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = clog2(NREQ_DEF)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  int idx;

  // Scan from the farthest offset back to ptr so the nearest set bit is written last.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        found   = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/step_sequencer_arbiter.sv
// rtl/step_sequencer_arbiter.sv - round-robin owner of the shared fixed-length step sequencer
module step_sequencer_arbiter
  import step_seq_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int STEPS  = STEPS_DEF,
  parameter int IDX_W  = clog2(NREQ),
  parameter int STEP_W = clog2(STEPS)
) (
  input  logic              clock150kHz,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic [IDX_W-1:0]  owner,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  output logic [NREQ-1:0]   done,
  output logic              aborted,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                step_valid_q, step_valid_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, busy_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                owner_req;
  logic                do_abort;
  logic [IDX_W-1:0]    next_ptr;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .found   (pick_found),
    .win_idx (pick_idx)
  );

  assign owner_req = req[owner_q];
  assign next_ptr  = IDX_W'((int'(owner_q) + 1) % NREQ);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    step_d       = '0;
    step_valid_d = 1'b0;
    done_d       = '0;
    aborted_d    = 1'b0;
    busy_d       = busy_q;
    do_abort     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_GRANT;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
        end
      end
      ST_GRANT: begin
        if (owner_req) begin
          state_d      = ST_RUN;
          step_valid_d = 1'b1;
        end else begin
          do_abort = 1'b1;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          do_abort = 1'b1;
        end else if (step_q == STEP_W'(STEPS - 1)) begin
          state_d         = ST_FINISH;
          done_d[owner_q] = 1'b1;
        end else begin
          step_d       = step_q + STEP_W'(1);
          step_valid_d = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = next_ptr;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // A dropped request forfeits the slot: the rotation still moves past this owner.
    if (do_abort) begin
      state_d   = ST_IDLE;
      grant_d   = '0;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
      ptr_d     = next_ptr;
    end
  end

  always_ff @(posedge clock150kHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      grant_q      <= '0;
      step_q       <= '0;
      step_valid_q <= 1'b0;
      done_q       <= '0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      step_q       <= step_d;
      step_valid_q <= step_valid_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign step       = step_q;
  assign step_valid = step_valid_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_step_sequencer_arbiter.sv
// tb/tb_step_sequencer_arbiter.sv - scoreboard bench for the step sequencer arbiter
module tb_step_sequencer_arbiter;

  localparam int NREQ  = 4;
  localparam int STEPS = 4;

  localparam int EV_GRANT = 0;
  localparam int EV_STEP  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ABORT = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic            clock150kHz;
  logic            reset;
  logic [3:0]      req;
  logic [3:0]      grant;
  logic [1:0]      owner;
  logic [1:0]      step;
  logic            step_valid;
  logic [3:0]      done;
  logic            aborted;
  logic            busy;

  int   checks;
  int   errors;
  int   cyc;
  int   model_ptr;
  bit   mon_en;
  logic [3:0] prev_grant;
  ev_t  exp_q[$];

  step_sequencer_arbiter #(
    .NREQ   (NREQ),
    .STEPS  (STEPS),
    .IDX_W  (2),
    .STEP_W (2)
  ) dut (
    .clock150kHz (clock150kHz),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .owner       (owner),
    .step        (step),
    .step_valid  (step_valid),
    .done        (done),
    .aborted     (aborted),
    .busy        (busy)
  );

  initial clock150kHz = 1'b0;
  always #5 clock150kHz = ~clock150kHz;

  initial cyc = 0;
  always @(posedge clock150kHz) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock150kHz);
      #1;
    end
  endtask

  // Winner is the first requester met when walking the ring from the pointer.
  function automatic int model_pick(input logic [3:0] m);
    for (int i = 0; i < NREQ; i++) begin
      if (m[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic ev_t mk(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    return e;
  endfunction

  // ab: -1 completes, 0 drops req during GRANT, j+1 drops req during step j.
  task automatic run_episode(input logic [3:0] m, input int ab);
    int t, w, e, drop_c, late_c;
    logic [3:0] one_w, late;
    t = cyc;
    req = m;
    w = model_pick(m);
    one_w = 4'b0001 << w;
    exp_q.push_back(mk(EV_GRANT, w, t + 1));
    if (ab < 0) begin
      for (int k = 0; k < STEPS; k++) exp_q.push_back(mk(EV_STEP, k, t + 2 + k));
      exp_q.push_back(mk(EV_DONE, w, t + STEPS + 2));
      e = t + STEPS + 3;
      drop_c = -1;
    end else if (ab == 0) begin
      exp_q.push_back(mk(EV_ABORT, 0, t + 2));
      e = t + 2;
      drop_c = t + 1;
    end else begin
      for (int k = 0; k < ab; k++) exp_q.push_back(mk(EV_STEP, k, t + 2 + k));
      exp_q.push_back(mk(EV_ABORT, 0, t + 2 + ab));
      e = t + 2 + ab;
      drop_c = t + 1 + ab;
    end
    model_ptr = (w + 1) % NREQ;
    late_c = $urandom_range(t + 1, e - 1);
    late = 4'($urandom) & ~one_w;
    for (int c = t + 1; c < e; c++) begin
      goto(c);
      if (c == drop_c) req = req & ~one_w;
      if (c == late_c) req = req | late;
    end
    goto(e);
  endtask

  task automatic match(input int kind, input int val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk(1'b0, {name, "_unexpected"}, kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk(e.kind == kind, {name, "_kind"}, kind, e.kind);
      chk(e.cyc == cyc, {name, "_cycle"}, cyc, e.cyc);
      if (e.kind == kind) begin
        if (kind == EV_GRANT) begin
          chk(int'(grant) == (1 << e.val), "grant_vec", int'(grant), 1 << e.val);
          chk(int'(owner) == e.val, "owner", int'(owner), e.val);
        end else if (kind == EV_STEP) begin
          chk(int'(step) == e.val, "step", int'(step), e.val);
        end else if (kind == EV_DONE) begin
          chk(int'(done) == (1 << e.val), "done_vec", int'(done), 1 << e.val);
        end else begin
          chk(grant == 4'b0000, "abort_grant", int'(grant), 0);
        end
      end
    end
  endtask

  always @(negedge clock150kHz) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk(1'b0, "missing_event", exp_q[0].kind, exp_q[0].val);
        void'(exp_q.pop_front());
      end
      chk($onehot0(grant), "grant_onehot", int'(grant), 0);
      chk(!(done != 4'b0000 && aborted), "done_with_abort", int'(done), 0);
      chk(!step_valid || busy, "valid_implies_busy", int'(busy), 1);
      chk(step_valid || step == 2'd0, "step_idle_zero", int'(step), 0);
      if (grant != 4'b0000 && prev_grant == 4'b0000) match(EV_GRANT, 0, "grant");
      if (step_valid) match(EV_STEP, 0, "step");
      if (done != 4'b0000) match(EV_DONE, 0, "done");
      if (aborted) match(EV_ABORT, 0, "abort");
      prev_grant = grant;
    end
  end

  initial begin
    logic [3:0] m;
    int ab, r, t;
    checks = 0;
    errors = 0;
    model_ptr = 0;
    mon_en = 1'b0;
    prev_grant = 4'b0000;
    reset = 1'b1;
    req = 4'b0000;
    repeat (3) @(posedge clock150kHz);
    #1;
    reset = 1'b0;
    goto(cyc + 2);

    // Reset in the middle of RUN while step 2 is showing.
    t = cyc;
    req = 4'b0010;
    goto(t + 4);
    #1;
    chk(step == 2'd2 && step_valid, "pre_reset_step", int'(step), 2);
    #2;
    reset = 1'b1;
    #1;
    chk(grant == 4'b0000, "rst_grant", int'(grant), 0);
    chk(owner == 2'd0, "rst_owner", int'(owner), 0);
    chk(step == 2'd0, "rst_step", int'(step), 0);
    chk(!step_valid, "rst_step_valid", int'(step_valid), 0);
    chk(done == 4'b0000, "rst_done", int'(done), 0);
    chk(!aborted, "rst_aborted", int'(aborted), 0);
    chk(!busy, "rst_busy", int'(busy), 0);
    @(posedge clock150kHz);
    #1;
    req = 4'b0000;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock150kHz);
      chk(!busy && grant == 4'b0000 && done == 4'b0000 && !aborted, "idle_after_reset", int'(busy), 0);
    end
    @(posedge clock150kHz);
    #1;
    model_ptr = 0;
    mon_en = 1'b1;

    // Contention from ptr=0, then wrap, then abort with rotation.
    for (int i = 0; i < 5; i++) run_episode(4'b1111, -1);
    run_episode(4'b0010, -1);
    run_episode(4'b0100, -1);
    run_episode(4'b0101, -1);
    run_episode(4'b0101, -1);
    run_episode(4'b0010, 2);
    run_episode(4'b0011, -1);

    for (int i = 0; i < 60; i++) begin
      m = (req & 4'($urandom)) | (4'($urandom) & 4'($urandom));
      if (m == 4'b0000) begin
        req = 4'b0000;
        goto(cyc + $urandom_range(1, 3));
        m = 4'($urandom_range(1, 15));
      end
      r = $urandom_range(0, 9);
      ab = (r < 6) ? -1 : $urandom_range(0, STEPS);
      run_episode(m, ab);
    end

    req = 4'b0000;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clock150kHz);
    goto(cyc + 3);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
